// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control logic.
//   REG_IDX_W   : width of a register index
//   ALUOP_NOP   : aluop carried by an ID/EX bubble
//   hz_state_t  : hazard controller FSM encoding
package pipe_pkg;

    localparam int          REG_IDX_W = 6;
    localparam logic [2:0]  ALUOP_NOP = 3'b011;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// Ports:
//   id_rs, id_rt, id_uses_rt : source operands of the instruction in ID
//   ex_rd, ex_memrd          : destination and load flag of the instruction in EX
//   hz                       : ID must wait one cycle for the load result
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int R0_ZERO = 1
) (
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memrd,
    output logic                 hz
);

    logic rd_is_zero;

    // Register 0 is hard-wired, so a load targeting it never produces data.
    assign rd_is_zero = (R0_ZERO != 0) && (ex_rd == '0);

    assign hz = ex_memrd && !rd_is_zero &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard / sequencing controller for the 5-stage pipeline.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   id_rs, id_rt, id_uses_rt        : ID stage operands
//   ex_rd, ex_memrd                 : ID/EX destination and load flag
//   redirect                        : taken branch / jump resolved in MEM
//   mem_busy                        : data memory not ready, hold everything
//   pc_wr_en, ifid_wr_en            : buffer write enables
//   ifid_flush, idex_bubble,
//   exmem_flush, freeze             : buffer kill / hold controls
//   state                           : FSM state
//   stall_cnt, flush_cnt            : saturating event counters
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal issue; hazards and redirects detected here
// LDSTALL | remaining load-use bubble cycles (cnt counts down to 1)
// FLUSH   | extra IF/ID kill cycles after a redirect (cnt counts down)
// MEMWAIT | whole pipe frozen; resume register picks RUN or LDSTALL
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_STALLS = 1,
    parameter int FLUSH_EXTRA = 1,
    parameter int CNT_W       = 16,
    parameter int R0_ZERO     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memrd,
    input  logic                 redirect,
    input  logic                 mem_busy,
    output logic                 pc_wr_en,
    output logic                 ifid_wr_en,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 exmem_flush,
    output logic                 freeze,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALLS - 1);
    localparam logic [2:0] FE_RELOAD = 3'(FLUSH_EXTRA);

    hz_state_t  state_q, state_d, eff;
    logic [2:0] cnt_q, cnt_d;
    logic       resume_q, resume_d;
    logic       stall_inc, flush_inc;
    logic       hz;

    hazard_detect #(.R0_ZERO(R0_ZERO)) u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_rd      (ex_rd),
        .ex_memrd   (ex_memrd),
        .hz         (hz)
    );

    assign state = state_q;

    always_comb begin
        pc_wr_en    = 1'b0;
        ifid_wr_en  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        freeze      = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        resume_d    = resume_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        // Leaving MEMWAIT behaves exactly like the resume state in the same cycle.
        eff = state_q;
        if (state_q == MEMWAIT && !mem_busy)
            eff = resume_q ? LDSTALL : RUN;

        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_q == MEMWAIT && mem_busy) begin
            // MEM keeps redirect asserted until the freeze ends, so ignore it here.
            freeze = 1'b1;
        end else if (redirect) begin
            pc_wr_en    = 1'b1;
            ifid_wr_en  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
            if (FLUSH_EXTRA > 0) begin
                state_d = FLUSH;
                cnt_d   = FE_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else if (mem_busy) begin
            // A freeze during FLUSH resumes in RUN; the held fetch is not advanced.
            freeze   = 1'b1;
            state_d  = MEMWAIT;
            resume_d = (eff == LDSTALL);
        end else begin
            case (eff)
                FLUSH: begin
                    pc_wr_en   = 1'b1;
                    ifid_wr_en = 1'b1;
                    ifid_flush = 1'b1;
                    cnt_d      = cnt_q - 3'd1;
                    state_d    = (cnt_q == 3'd1) ? RUN : FLUSH;
                end
                LDSTALL: begin
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    state_d     = (cnt_q == 3'd1) ? RUN : LDSTALL;
                end
                default: begin
                    if (hz) begin
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        if (LOAD_STALLS > 1) begin
                            state_d = LDSTALL;
                            cnt_d   = LS_RELOAD;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        pc_wr_en   = 1'b1;
                        ifid_wr_en = 1'b1;
                        state_d    = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            resume_q  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resume_q <= resume_d;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_STALLS=1/CNT_W=16 and
// LOAD_STALLS=3/CNT_W=4) share one stimulus stream; a behavioural model
// pushes expected outputs into a scoreboard each cycle.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_memrd, redirect, mem_busy;

    logic        pc_wr_en_a, ifid_wr_en_a, ifid_flush_a, idex_bubble_a, exmem_flush_a, freeze_a;
    logic [1:0]  state_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic        pc_wr_en_b, ifid_wr_en_b, ifid_flush_b, idex_bubble_b, exmem_flush_b, freeze_b;
    logic [1:0]  state_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_STALLS(1), .FLUSH_EXTRA(1), .CNT_W(16), .R0_ZERO(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_memrd(ex_memrd), .redirect(redirect), .mem_busy(mem_busy),
        .pc_wr_en(pc_wr_en_a), .ifid_wr_en(ifid_wr_en_a), .ifid_flush(ifid_flush_a),
        .idex_bubble(idex_bubble_a), .exmem_flush(exmem_flush_a), .freeze(freeze_a),
        .state(state_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));

    pipeline_hazard_ctrl #(.LOAD_STALLS(3), .FLUSH_EXTRA(1), .CNT_W(4), .R0_ZERO(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_memrd(ex_memrd), .redirect(redirect), .mem_busy(mem_busy),
        .pc_wr_en(pc_wr_en_b), .ifid_wr_en(ifid_wr_en_b), .ifid_flush(ifid_flush_b),
        .idex_bubble(idex_bubble_b), .exmem_flush(exmem_flush_b), .freeze(freeze_b),
        .state(state_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

    typedef struct packed {
        logic [5:0]  ctl;   // {pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, exmem_flush, freeze}
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // model state per instance
    int m_state[2], m_cnt[2], m_res[2], m_stall[2], m_flush[2];
    int p_ls[2]   = '{1, 3};
    int p_fe[2]   = '{1, 1};
    int p_max[2]  = '{65535, 15};

    logic [5:0] obs_a, obs_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval(input int i, output logic [5:0] ctl, output int ns, output int nc,
                              output int nr, output int nst, output int nfl);
        int  s;
        bit  hzm;
        hzm = ex_memrd && (ex_rd != 0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        ns = m_state[i]; nc = m_cnt[i]; nr = m_res[i]; nst = m_stall[i]; nfl = m_flush[i];
        ctl = 6'b000000;
        if (!rst_n) begin
            ctl = 6'b001110;
            ns = 0; nc = 0; nr = 0; nst = 0; nfl = 0;
            return;
        end
        s = m_state[i];
        if (s == 3) begin
            if (mem_busy) begin
                ctl = 6'b000001;
                return;
            end
            s = (m_res[i] != 0) ? 1 : 0;
        end
        if (redirect) begin
            ctl = 6'b111110;
            if (nfl < p_max[i]) nfl++;
            if (p_fe[i] > 0) begin ns = 2; nc = p_fe[i]; end
            else ns = 0;
        end else if (mem_busy) begin
            ctl = 6'b000001;
            ns = 3;
            nr = (s == 1) ? 1 : 0;
        end else if (s == 2) begin
            ctl = 6'b111000;
            ns = (m_cnt[i] == 1) ? 0 : 2;
            nc = m_cnt[i] - 1;
        end else if (s == 1) begin
            ctl = 6'b000100;
            ns = (m_cnt[i] == 1) ? 0 : 1;
            nc = m_cnt[i] - 1;
        end else if (hzm) begin
            ctl = 6'b000100;
            if (nst < p_max[i]) nst++;
            if (p_ls[i] > 1) begin ns = 1; nc = p_ls[i] - 1; end
            else ns = 0;
        end else begin
            ctl = 6'b110000;
            ns = 0;
        end
    endtask

    task automatic step();
        exp_t       e;
        logic [5:0] c;
        int         ns, nc, nr, nst, nfl;
        int         n_s[2], n_c[2], n_r[2], n_st[2], n_fl[2];
        #1;
        for (int i = 0; i < 2; i++) begin
            model_eval(i, c, ns, nc, nr, nst, nfl);
            e.ctl = c;
            e.st  = 2'(m_state[i]);
            e.sc  = 16'(m_stall[i]);
            e.fc  = 16'(m_flush[i]);
            sb_q.push_back(e);
            n_s[i] = ns; n_c[i] = nc; n_r[i] = nr; n_st[i] = nst; n_fl[i] = nfl;
        end
        obs_a = {pc_wr_en_a, ifid_wr_en_a, ifid_flush_a, idex_bubble_a, exmem_flush_a, freeze_a};
        obs_b = {pc_wr_en_b, ifid_wr_en_b, ifid_flush_b, idex_bubble_b, exmem_flush_b, freeze_b};
        e = sb_q.pop_front();
        check("a_ctl", obs_a, e.ctl);
        check("a_state", state_a, e.st);
        check("a_stall_cnt", stall_cnt_a, e.sc);
        check("a_flush_cnt", flush_cnt_a, e.fc);
        e = sb_q.pop_front();
        check("b_ctl", obs_b, e.ctl);
        check("b_state", state_b, e.st);
        check("b_stall_cnt", stall_cnt_b, e.sc);
        check("b_flush_cnt", flush_cnt_b, e.fc);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_state[i] = n_s[i]; m_cnt[i] = n_c[i]; m_res[i] = n_r[i];
            m_stall[i] = n_st[i]; m_flush[i] = n_fl[i];
        end
        #1;
    endtask

    task automatic drive(input logic [5:0] rd, input logic [5:0] rs, input logic [5:0] rt,
                         input logic ut, input logic ld, input logic rdr, input logic busy);
        ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rt = ut;
        ex_memrd = ld; redirect = rdr; mem_busy = busy;
    endtask

    task automatic idle();
        drive(6'd1, 6'd2, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int stalls_b, freezes_b;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        // reset held: bubbles everywhere, PC held
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_pc_wr_en", obs_a[5], 1'b1);
        repeat (2) step();

        // load-use on rs
        drive(6'd5, 6'd5, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("ldu_bubble_a", obs_a, 6'b000100);
        idle();
        repeat (3) step();
        check("ldu_stall_cnt_a", stall_cnt_a, 16'd1);

        // r0 destination never stalls
        drive(6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("r0_no_stall", obs_a, 6'b110000);

        // rt compare only when the instruction reads rt
        drive(6'd7, 6'd2, 6'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idle(); repeat (3) step();
        drive(6'd7, 6'd2, 6'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("rt_unused_no_stall", obs_a, 6'b110000);
        idle(); repeat (2) step();

        // redirect with one extra flush cycle
        drive(6'd1, 6'd2, 6'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("redirect_state", state_a, 2'd2);
        idle();
        step();
        check("flush_only_ifid", obs_a, 6'b111000);
        check("flush_done_state", state_a, 2'd0);
        check("flush_cnt_a", flush_cnt_a, 16'd1);
        repeat (2) step();

        // redirect and hazard together: redirect wins
        drive(6'd4, 6'd4, 6'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check("rdr_hz_bubble", obs_a[2], 1'b1);
        check("rdr_hz_stall_a", stall_cnt_a, 16'd2);
        check("rdr_hz_flush_a", flush_cnt_a, 16'd2);
        idle(); repeat (3) step();

        // 3-cycle load stall interrupted by a 2-cycle freeze
        stalls_b = 0; freezes_b = 0;
        drive(6'd6, 6'd6, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        if (obs_b[2] && !obs_b[0]) stalls_b++;
        if (obs_b[0]) freezes_b++;
        drive(6'd1, 6'd2, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) idle();
            step();
            if (obs_b[2] && !obs_b[0]) stalls_b++;
            if (obs_b[0]) freezes_b++;
        end
        check("ldstall_cycles_b", stalls_b, 3);
        check("freeze_cycles_b", freezes_b, 2);

        // redirect while frozen is ignored, then honoured once memory is ready
        drive(6'd1, 6'd2, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        redirect = 1'b1;
        step();
        check("memwait_rdr_ignored", obs_a, 6'b000001);
        mem_busy = 1'b0;
        step();
        check("memwait_rdr_taken", obs_a, 6'b111110);
        idle(); repeat (3) step();

        // saturation on the 4-bit counter
        for (int h = 0; h < 17; h++) begin
            drive(6'd8, 6'd8, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0);
            step();
            idle();
            repeat (3) step();
        end
        check("stall_sat_b", stall_cnt_b, 4'd15);

        // randomised traffic
        for (int r = 0; r < 300; r++) begin
            drive(6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
            step();
        end
        idle();
        repeat (4) step();

        // reset asserted during FLUSH
        redirect = 1'b1;
        step();
        check("pre_rst_flush_state", state_a, 2'd2);
        redirect = 1'b0;
        rst_n = 1'b0;
        step();
        check("rst_flush_state_a", state_a, 2'd0);
        check("rst_flush_stall_b", stall_cnt_b, 4'd0);
        check("rst_flush_flush_a", flush_cnt_a, 16'd0);
        rst_n = 1'b1;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage 32-bit pipeline. It drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM buffers.
- Load-use hazards: stalls IF/ID and inserts an ID/EX bubble.
- Taken branches and jumps resolved in MEM: flushes wrong-path stages.
- Multi-cycle memory access: freezes the whole pipe.
- Keeps stall and flush event counters for performance checks.

Parameters:
LOAD_STALLS, 1, bubble cycles inserted per load-use hazard (1..7)
FLUSH_EXTRA, 1, extra IF/ID flush cycles after a redirect to kill the fetch in flight (0..7)
CNT_W, 16, width of the stall and flush event counters
R0_ZERO, 1, when 1 a register index of 0 never creates a hazard

Ports:
clk  in  1  pipeline clock, rising-edge active
rst_n  in  1  synchronous active-low reset
id_rs  in  6  source register index of the instruction in ID
id_rt  in  6  second source register index of the instruction in ID
id_uses_rt  in  1  instruction in ID reads id_rt
ex_rd  in  6  destination index held in ID/EX
ex_memrd  in  1  instruction in EX is a load
redirect  in  1  branch taken or jump resolved in MEM this cycle
mem_busy  in  1  data memory not ready; the whole pipe must hold
pc_wr_en  out  1  PC may update
ifid_wr_en  out  1  IF/ID may capture
ifid_flush  out  1  IF/ID captures a NOP
idex_bubble  out  1  ID/EX captures all-zero control with aluop 3'b011
exmem_flush  out  1  EX/MEM captures all-zero control
freeze  out  1  every pipeline buffer holds its contents
state  out  2  FSM state: RUN=0, LDSTALL=1, FLUSH=2, MEMWAIT=3
stall_cnt  out  CNT_W  load-use hazards detected, saturating
flush_cnt  out  CNT_W  redirects taken, saturating

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- While rst_n=0:
  - state=RUN; internal down-counter cnt=0; stall_cnt=0; flush_cnt=0.
  - Control outputs: pc_wr_en=0, ifid_wr_en=0, ifid_flush=1, idex_bubble=1, exmem_flush=1, freeze=0.
  - Effect: the pipe fills with bubbles.
- Control outputs are combinational from state, cnt and the current inputs (zero-cycle latency). state, cnt and the counters are registered.
- Load-use hazard (hz) = ex_memrd & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)). When R0_ZERO=1 and ex_rd==0, hz=0.
- Priority each cycle: redirect > mem_busy > hz > normal.
- RUN:
  - redirect: ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_wr_en=1, flush_cnt++. If FLUSH_EXTRA>0, next state=FLUSH with cnt=FLUSH_EXTRA.
  - else mem_busy: freeze=1, pc_wr_en=0, ifid_wr_en=0. Next state=MEMWAIT, cnt preserved.
  - else hz: pc_wr_en=0, ifid_wr_en=0, idex_bubble=1, stall_cnt++. If LOAD_STALLS>1, next state=LDSTALL with cnt=LOAD_STALLS-1.
  - else: pc_wr_en=1, ifid_wr_en=1, all flush/bubble signals 0.
- LDSTALL:
  - Drives the same outputs as a RUN hazard cycle; does not increment stall_cnt.
  - cnt decrements each cycle; return to RUN when cnt reaches 1.
  - redirect aborts the stall: behave as a RUN redirect.
  - mem_busy moves to MEMWAIT and remembers LDSTALL as the return state (1-bit resume register).
- FLUSH:
  - pc_wr_en=1, ifid_wr_en=1, ifid_flush=1; other flush/bubble signals 0.
  - cnt decrements each cycle; return to RUN after the cycle where cnt==1.
  - A new redirect reloads cnt=FLUSH_EXTRA, drives full RUN-redirect outputs and increments flush_cnt.
- MEMWAIT:
  - freeze=1, pc_wr_en=0, ifid_wr_en=0, all flush/bubble signals 0; cnt holds.
  - When mem_busy=0, return to the resume state (RUN or LDSTALL) in the same cycle and drive that state's outputs.
  - redirect while mem_busy=1 is ignored. The MEM stage holds redirect until the freeze ends.
- Counters saturate at all-ones, never wrap. Both counters increment only on the event cycle, never on continuation cycles.
- Reset asserted mid-operation in any state: the next edge applies the reset values. Pending cnt and resume state are discarded.

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants: RUN, LDSTALL, FLUSH, MEMWAIT
  - ALUOP_NOP = 3'b011
  - REG_IDX_W = 6
- One natural sub-module: hazard_detect, the combinational hz compare. It is reused later by the forwarding unit.
- Saturating counter stays inline.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 with no hazards. During reset ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_wr_en=0. First cycle after reset: pc_wr_en=1, state=RUN, counters 0.
- Load-use: ex_memrd=1, ex_rd=5, id_rs=5, LOAD_STALLS=1. Exactly one cycle of pc_wr_en=0, ifid_wr_en=0, idex_bubble=1; stall_cnt=1. Repeat with ex_rd=0 and R0_ZERO=1: no stall.
- Redirect with FLUSH_EXTRA=1: redirect=1 for one cycle. That cycle: all three flush signals=1. Next cycle: state=FLUSH, ifid_flush=1 only. Then RUN; flush_cnt=1.
- Redirect and hz in the same cycle: flush wins. stall_cnt unchanged, flush_cnt+1, idex_bubble=1.
- LOAD_STALLS=3, mem_busy=1 for 2 cycles during the 2nd stall cycle. freeze=1 for those 2 cycles. Then LDSTALL resumes for the remaining cycles: 3 stall cycles total, excluding the frozen cycles.
- Saturation: CNT_W=4 with 17 hazards. stall_cnt stops at 15. Reset asserted during FLUSH returns to RUN with counters 0.
